// File: rtl/fb_capture_writer_pkg.sv
// Shared capture/filter definitions: FSM state encoding, default camera and
// frame-buffer geometry, and the RGB565 pixel type.
package fb_capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARM     = 2'd1,
    CAP_CAPTURE = 2'd2
  } cap_state_e;

  localparam int DEF_SRC_WIDTH  = 640;
  localparam int DEF_SRC_HEIGHT = 480;
  localparam int DEF_DECIM      = 4;
  localparam int DEF_IMG_WIDTH  = 160;
  localparam int DEF_IMG_HEIGHT = 120;
  localparam int PIX_W          = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // The OV7670 sends the high half of each RGB565 word first.
  function automatic rgb565_t rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/fb_capture_writer_if.sv
// Camera byte stream in, frame-buffer write port out. The capture block uses
// the slave view; the camera/frame-buffer side uses the master view.
interface fb_capture_writer_if
  import fb_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
);
  logic                  cam_vsync;
  logic                  cam_href;
  logic                  cam_byte_valid;
  logic [7:0]            cam_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [PIX_W-1:0]      wr_data;

  modport master (
    output cam_vsync, cam_href, cam_byte_valid, cam_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cam_vsync, cam_href, cam_byte_valid, cam_data,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/fb_capture_writer_cam_byte_assembler.sv
// Edge detection on vsync/href, pairing of camera bytes into RGB565 pixels,
// and per-line pixel count / line integrity check.
module cam_byte_assembler
  import fb_capture_pkg::*;
#(
  parameter int SRC_WIDTH = DEF_SRC_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic       byte_valid_i,
  input  logic [7:0] data_i,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o,
  output logic       pix_valid_o,
  output rgb565_t    pix_data_o,
  output logic       line_start_o,
  output logic       line_end_o,
  output logic       line_err_o
);
  localparam int             CW      = $clog2(SRC_WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SRC_WIDTH);

  logic          vsync_q, href_q;
  logic          href_rise, href_fall, byte_ok;
  logic          phase_q, phase_d, phase_b;
  logic          seen_q, seen_d, seen_b;
  logic          ovf_q, ovf_d, ovf_b;
  logic [CW-1:0] cnt_q, cnt_d, cnt_b;
  logic [7:0]    hi_q, hi_d;

  assign href_rise    = href_i & ~href_q;
  assign href_fall    = ~href_i & href_q;
  assign vsync_rise_o = vsync_i & ~vsync_q;
  assign vsync_fall_o = ~vsync_i & vsync_q;
  assign byte_ok      = en_i & href_i & byte_valid_i;
  assign line_start_o = en_i & href_rise;

  // A new line restarts pairing even when its first byte lands on the rising edge.
  assign phase_b = href_rise ? 1'b0 : phase_q;
  assign seen_b  = href_rise ? 1'b0 : seen_q;
  assign ovf_b   = href_rise ? 1'b0 : ovf_q;
  assign cnt_b   = href_rise ? '0   : cnt_q;

  assign pix_valid_o = byte_ok & phase_b;
  assign pix_data_o  = rgb565_pack(hi_q, data_i);

  always_comb begin
    phase_d = byte_ok ? ~phase_b : phase_b;
    seen_d  = seen_b | byte_ok;
    ovf_d   = ovf_b | (pix_valid_o & (cnt_b == CNT_MAX));
    cnt_d   = (pix_valid_o && cnt_b != CNT_MAX) ? cnt_b + 1'b1 : cnt_b;
    hi_d    = (byte_ok & ~phase_b) ? data_i : hi_q;
    // End of line sees this cycle's byte first; a half pixel left over is dropped.
    line_end_o = en_i & href_fall & seen_d;
    line_err_o = line_end_o & ((cnt_d != CNT_MAX) | ovf_d | phase_d);
    if (href_fall || clr_i) begin
      phase_d = 1'b0;
      seen_d  = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
    end else begin
      vsync_q <= vsync_i;
      href_q  <= href_i;
      phase_q <= phase_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
    end
  end
endmodule

// File: rtl/fb_capture_writer.sv
// Whole-frame capture FSM, DECIM x DECIM decimation into the frame buffer,
// and per-frame completion / integrity reporting.
module fb_capture_writer
  import fb_capture_pkg::*;
#(
  parameter int SRC_WIDTH  = DEF_SRC_WIDTH,
  parameter int SRC_HEIGHT = DEF_SRC_HEIGHT,
  parameter int DECIM      = DEF_DECIM,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture_en_i,
  fb_capture_writer_if.slave  bus,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                frame_err_o
);
  localparam logic [1:0] S_IDLE    = 2'(CAP_IDLE);
  localparam logic [1:0] S_ARM     = 2'(CAP_ARM);
  localparam logic [1:0] S_CAPTURE = 2'(CAP_CAPTURE);

  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int DXW = $clog2(IMG_WIDTH + 1);
  localparam int DYW = $clog2(IMG_HEIGHT + 1);
  localparam int SYW = $clog2(SRC_HEIGHT + 2);

  localparam logic [PW-1:0]         PH_LAST = PW'(DECIM - 1);
  localparam logic [DXW-1:0]        DX_MAX  = DXW'(IMG_WIDTH);
  localparam logic [DYW-1:0]        DY_MAX  = DYW'(IMG_HEIGHT);
  localparam logic [SYW-1:0]        SY_OK   = SYW'(SRC_HEIGHT);
  localparam logic [SYW-1:0]        SY_MAX  = SYW'(SRC_HEIGHT + 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_W   = ADDR_WIDTH'(IMG_WIDTH);

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         xph_q, xph_d, yph_q, yph_d;
  logic [DXW-1:0]        dx_q, dx_d;
  logic [DYW-1:0]        dy_q, dy_d;
  logic [SYW-1:0]        sy_q, sy_d;
  logic                  err_acc_q, err_acc_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  rgb565_t               wr_data_q, wr_data_d;
  logic                  done_q, done_d, ferr_q, ferr_d;

  logic    clr, capturing, keep;
  logic    vsync_rise, vsync_fall, pix_valid, line_start, line_end, line_err;
  rgb565_t pix_data;

  assign capturing = (state_q == S_CAPTURE);

  cam_byte_assembler #(
    .SRC_WIDTH (SRC_WIDTH)
  ) u_asm (
    .clk          (clk),
    .reset        (reset),
    .en_i         (capturing),
    .clr_i        (clr),
    .vsync_i      (bus.cam_vsync),
    .href_i       (bus.cam_href),
    .byte_valid_i (bus.cam_byte_valid),
    .data_i       (bus.cam_data),
    .vsync_rise_o (vsync_rise),
    .vsync_fall_o (vsync_fall),
    .pix_valid_o  (pix_valid),
    .pix_data_o   (pix_data),
    .line_start_o (line_start),
    .line_end_o   (line_end),
    .line_err_o   (line_err)
  );

  assign keep = (xph_q == '0) && (yph_q == '0) && (dx_q < DX_MAX) && (dy_q < DY_MAX);

  always_comb begin
    state_d   = state_q;
    xph_d     = xph_q;
    yph_d     = yph_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    sy_d      = sy_q;
    err_acc_d = err_acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: if (capture_en_i) state_d = S_ARM;
      S_ARM: begin
        // Only a vsync falling edge starts a frame, so capture never begins mid-frame.
        if (!capture_en_i) begin
          state_d = S_IDLE;
        end else if (vsync_fall) begin
          state_d   = S_CAPTURE;
          clr       = 1'b1;
          xph_d     = '0;
          yph_d     = '0;
          dx_d      = '0;
          dy_d      = '0;
          sy_d      = '0;
          err_acc_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (line_start) begin
          xph_d = '0;
          dx_d  = '0;
        end
        if (pix_valid) begin
          if (keep) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WIDTH'(dy_q) * ROW_W + ADDR_WIDTH'(dx_q);
            wr_data_d = pix_data;
          end
          if (xph_q == PH_LAST) begin
            xph_d = '0;
            if (dx_q != DX_MAX) dx_d = dx_q + 1'b1;
          end else begin
            xph_d = xph_q + 1'b1;
          end
        end
        if (line_end) begin
          xph_d = '0;
          dx_d  = '0;
          if (sy_q != SY_MAX) sy_d = sy_q + 1'b1;
          if (yph_q == PH_LAST) begin
            yph_d = '0;
            if (dy_q != DY_MAX) dy_d = dy_q + 1'b1;
          end else begin
            yph_d = yph_q + 1'b1;
          end
          if (line_err) err_acc_d = 1'b1;
        end
        if (vsync_rise) begin
          done_d  = 1'b1;
          ferr_d  = err_acc_d | (sy_d != SY_OK);
          state_d = capture_en_i ? S_ARM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      xph_q     <= '0;
      yph_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      sy_q      <= '0;
      err_acc_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      xph_q     <= xph_d;
      yph_q     <= yph_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      sy_q      <= sy_d;
      err_acc_q <= err_acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy_o       = (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign frame_done_o = done_q;
  assign frame_err_o  = ferr_q;
endmodule

// File: doc/fb_capture_writer.md
Name: fb_capture_writer

Overview:
- Upstream neighbour of the kaleidoscope/mirror filter stage.
- Takes the OV7670 byte stream (already synchronised to clk), assembles RGB565 pixels and decimates the source frame by DECIM in both axes.
- Writes the decimated 160x120 image into the frame buffer that the filters read by address.
- Gates capture on whole frames and reports frame completion and frame integrity.

Parameters:
- SRC_WIDTH, 640, active pixels per camera line.
- SRC_HEIGHT, 480, active lines per camera frame.
- DECIM, 4, decimation factor in x and y. SRC_WIDTH = IMG_WIDTH*DECIM and SRC_HEIGHT = IMG_HEIGHT*DECIM.
- IMG_WIDTH, 160, frame buffer width.
- IMG_HEIGHT, 120, frame buffer height.
- ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), frame buffer address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- capture_en  in  1  level; 1 = capture frames continuously.
- cam_vsync  in  1  high during vertical blanking.
- cam_href  in  1  high during an active line.
- cam_byte_valid  in  1  one-cycle strobe, cam_data valid.
- cam_data  in  8  camera byte; first byte of a pair = RGB565[15:8].
- wr_en  out  1  frame buffer write strobe.
- wr_addr  out  ADDR_WIDTH  write address, dst_y*IMG_WIDTH + dst_x.
- wr_data  out  16  RGB565 pixel.
- busy  out  1  high in ARM or CAPTURE.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_err  out  1  valid with frame_done; 1 = malformed frame.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-frame abandons the frame; no frame_done is produced.
- Edges: cam_vsync and cam_href are registered once internally to detect edges. Bytes are counted only when cam_href=1 and cam_byte_valid=1.
- FSM IDLE:
  - stays while capture_en=0;
  - capture_en=1 -> ARM.
- FSM ARM (never starts mid-frame):
  - waits for cam_vsync high, then a vsync falling edge;
  - on that edge clear counters -> CAPTURE;
  - capture_en=0 while in ARM -> IDLE.
- FSM CAPTURE:
  - href rising edge: byte phase <= 0, src_x <= 0.
  - Phase 0 byte: latch into hi register, phase <= 1.
  - Phase 1 byte: pixel = {hi, cam_data}, phase <= 0, src_x++ (saturates at SRC_WIDTH).
  - Pixel kept iff x_phase==0 and y_phase==0 and dst_x<IMG_WIDTH and dst_y<IMG_HEIGHT.
  - x_phase/y_phase are counters 0..DECIM-1; dst_x/dst_y advance when their phase wraps to 0.
  - Kept pixel: wr_en=1 with wr_addr/wr_data on the cycle after the second byte (latency 1, registered). wr_en is otherwise 0.
  - Out-of-range pixels are never written, so the address never exceeds IMG_WIDTH*IMG_HEIGHT-1.
  - href falling edge: if the line had >=1 byte, then src_y++, y_phase advances, dst_x/x_phase <= 0.
  - Line error, latched sticky in err_acc: completed-pixel count != SRC_WIDTH, or phase==1 at href fall (dangling byte, discarded).
  - vsync rising edge: frame_done=1 for one cycle.
  - Frame error at that edge: frame_err = err_acc OR (src_y != SRC_HEIGHT).
  - Next state: ARM if capture_en=1, else IDLE. capture_en falling mid-CAPTURE still completes the current frame.
- Simultaneous events:
  - A second byte in the same cycle as href falling: the byte is consumed first, then end-of-line is processed.
  - A vsync rise in the same cycle as a pending write: the write still issues that cycle.
- Arithmetic: the address multiply uses a constant IMG_WIDTH. All counters are sized with $clog2(max+1) and never wrap silently.

Decomposition:
- Package fb_capture_pkg: state enum (IDLE, ARM, CAPTURE), default geometry constants, and the RGB565 pixel typedef. These are shared with the filter stages and the frame buffer.
- One natural sub-module, cam_byte_assembler, owning edge detection, byte pairing and the per-line pixel count/error. It outputs pix_valid, pix_data, line_start, line_end and line_err.
- The top level holds the FSM, decimation counters, address generation and frame status.

Test Plan:
All directed tests use SRC 8x4, DECIM 2, IMG 4x2.
- Full frame, capture_en=1, pixels 16'h0000..16'h001F in raster order -> exactly 8 writes:
  - addr 0..3 with data 0x0000, 0x0002, 0x0004, 0x0006;
  - addr 4..7 with data 0x0010, 0x0012, 0x0014, 0x0016;
  - then frame_done=1, frame_err=0 on the vsync rise.
- capture_en rises mid-frame -> no writes until the next vsync fall; the following frame matches scenario 1.
- Line 1 carries 7 pixels plus a dangling byte -> frame_done=1 with frame_err=1; no write ever has address >=8.
- Extra 5th line and extra pixels on line 0 -> writes are limited to addr 0..7; frame_err=1.
- capture_en dropped after line 2 -> frame completes with frame_done=1, state returns to IDLE, busy=0, and the next frame produces no writes.
- reset asserted mid-line -> next cycle wr_en=0, busy=0, frame_done=0; no frame_done ever follows for that frame.
